// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch FSM with one outstanding imem request and IF/ID pipeline register
module fetch_stage #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  ex_addr_in,
  input  logic               ex_redirect,
  input  logic               id_stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic               ifid_valid
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx, ifid_pc_nx;
  logic [INSTR_W-1:0] skid, skid_nx, ifid_instr_nx;
  logic kill, kill_nx, ifid_valid_nx, live;
  // live keeps imem_req low until the first edge after reset release
  assign imem_req = live && state == S_REQ;
  assign imem_addr = pc;
  // next-state and IF/ID update; redirect overrides everything at the end
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    kill_nx = kill;
    skid_nx = skid;
    ifid_pc_nx = ifid_pc;
    ifid_instr_nx = ifid_instr;
    ifid_valid_nx = id_stall ? ifid_valid : 1'b0;
    case (state)
      S_REQ: if (imem_req && imem_ready) state_nx = S_WAIT;
      S_WAIT: if (imem_rvalid) begin
        if (kill) begin
          kill_nx = 1'b0;
          state_nx = S_REQ;
        end else if (!id_stall) begin
          ifid_pc_nx = pc;
          ifid_instr_nx = imem_rdata;
          ifid_valid_nx = 1'b1;
          pc_nx = pc + ADDR_W'(4);
          state_nx = S_REQ;
        end else begin
          skid_nx = imem_rdata;
          state_nx = S_HOLD;
        end
      end
      S_HOLD: if (!id_stall) begin
        ifid_pc_nx = pc;
        ifid_instr_nx = skid;
        ifid_valid_nx = 1'b1;
        pc_nx = pc + ADDR_W'(4);
        state_nx = S_REQ;
      end
      default: state_nx = S_REQ;
    endcase
    if (ex_redirect) begin
      pc_nx = ex_addr_in;
      skid_nx = skid;
      ifid_pc_nx = ifid_pc;
      ifid_instr_nx = NOP_INSTR;
      ifid_valid_nx = 1'b0;
      kill_nx = state == S_REQ ? imem_req && imem_ready : state == S_WAIT ? !imem_rvalid : 1'b0;
      state_nx = state == S_REQ ? (imem_req && imem_ready ? S_WAIT : S_REQ) :
                 state == S_WAIT ? (imem_rvalid ? S_REQ : S_WAIT) : S_REQ;
    end
  end
  // state, PC, skid and IF/ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
      live <= 1'b0;
      pc <= RESET_PC;
      kill <= 1'b0;
      skid <= NOP_INSTR;
      ifid_pc <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else begin
      state <= state_nx;
      live <= 1'b1;
      pc <= pc_nx;
      kill <= kill_nx;
      skid <= skid_nx;
      ifid_pc <= ifid_pc_nx;
      ifid_instr <= ifid_instr_nx;
      ifid_valid <= ifid_valid_nx;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, reset corner sequence and randomized run against a transaction model
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0, rst_n = 0, ex_redirect = 0, id_stall = 0, imem_ready = 0, imem_rvalid = 0;
  logic imem_req, ifid_valid;
  logic [7:0] ex_addr_in = 0, imem_addr, ifid_pc;
  logic [31:0] imem_rdata = 0, ifid_instr;
  int errors = 0, checks = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_addr_in(ex_addr_in), .ex_redirect(ex_redirect),
    .id_stall(id_stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .ifid_pc(ifid_pc),
    .ifid_instr(ifid_instr), .ifid_valid(ifid_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rd; logic [7:0] ea; logic st, rdy, rv; logic [31:0] rdat;
    logic req; logic [7:0] addr; logic v; logic [7:0] pc; logic [31:0] ins;
  } vec_t;
  vec_t tbl[24];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [7:0] a, input logic v,
                         input logic [7:0] p, input logic [31:0] i);
    chk({tag, " imem_req"}, 32'(imem_req), 32'(req));
    chk({tag, " imem_addr"}, 32'(imem_addr), 32'(a));
    chk({tag, " ifid_valid"}, 32'(ifid_valid), 32'(v));
    chk({tag, " ifid_pc"}, 32'(ifid_pc), 32'(p));
    chk({tag, " ifid_instr"}, ifid_instr, i);
  endtask

  task automatic drive(input logic rd, input logic [7:0] ea, input logic st, input logic rdy,
                       input logic rv, input logic [31:0] rdat);
    ex_redirect = rd; ex_addr_in = ea; id_stall = st; imem_ready = rdy; imem_rvalid = rv; imem_rdata = rdat;
  endtask

  // transaction-level reference: a fetch is either idle, in flight (maybe doomed) or parked in a holding queue
  logic [7:0] m_pc, m_ifpc, m_req_addr;
  logic [31:0] m_instr;
  logic m_valid, m_busy, m_doomed, m_started;
  logic [31:0] m_held[$];

  function automatic logic [31:0] word(input logic [7:0] a);
    return {8'hC0, a, ~a, 8'h33};
  endfunction

  task automatic model_reset();
    m_pc = 0; m_ifpc = 0; m_instr = NOP; m_valid = 0;
    m_busy = 0; m_doomed = 0; m_started = 0; m_req_addr = 0;
    m_held.delete();
  endtask

  task automatic model_step(input logic rd, input logic [7:0] ea, input logic st, input logic rdy,
                            input logic rv, input logic [31:0] rdat);
    bit req = m_started && !m_busy && m_held.size() == 0;
    if (rd) begin
      m_pc = ea; m_valid = 0; m_instr = NOP;
      m_held.delete();
      if (m_busy) begin
        if (rv) begin m_busy = 0; m_doomed = 0; end
        else m_doomed = 1;
      end else if (req && rdy) begin
        m_busy = 1; m_doomed = 1;
      end
    end else begin
      if (!st) m_valid = 0;
      if (m_held.size() != 0) begin
        if (!st) begin
          m_ifpc = m_pc; m_instr = m_held.pop_front(); m_valid = 1; m_pc = m_pc + 8'd4;
        end
      end else if (m_busy) begin
        if (rv) begin
          m_busy = 0;
          if (m_doomed) m_doomed = 0;
          else if (!st) begin
            m_ifpc = m_pc; m_instr = rdat; m_valid = 1; m_pc = m_pc + 8'd4;
          end else m_held.push_back(rdat);
        end
      end else if (req && rdy) begin
        m_busy = 1; m_req_addr = m_pc;
      end
    end
    m_started = 1;
  endtask

  initial begin
    tbl[0]  = '{0, 8'h00, 0, 0, 0, 32'h0,        1, 8'h00, 0, 8'h00, NOP};
    tbl[1]  = '{0, 8'h00, 0, 1, 0, 32'h0,        0, 8'h00, 0, 8'h00, NOP};
    tbl[2]  = '{0, 8'h00, 0, 0, 1, 32'h00500093, 1, 8'h04, 1, 8'h00, 32'h00500093};
    tbl[3]  = '{0, 8'h00, 1, 1, 0, 32'h0,        0, 8'h04, 1, 8'h00, 32'h00500093};
    tbl[4]  = '{0, 8'h00, 1, 0, 1, 32'h00A00113, 0, 8'h04, 1, 8'h00, 32'h00500093};
    tbl[5]  = '{0, 8'h00, 1, 0, 0, 32'h0,        0, 8'h04, 1, 8'h00, 32'h00500093};
    tbl[6]  = '{0, 8'h00, 0, 0, 0, 32'h0,        1, 8'h08, 1, 8'h04, 32'h00A00113};
    tbl[7]  = '{0, 8'h00, 0, 1, 0, 32'h0,        0, 8'h08, 0, 8'h04, 32'h00A00113};
    tbl[8]  = '{1, 8'h28, 0, 0, 0, 32'h0,        0, 8'h28, 0, 8'h04, NOP};
    tbl[9]  = '{0, 8'h00, 0, 0, 0, 32'h0,        0, 8'h28, 0, 8'h04, NOP};
    tbl[10] = '{0, 8'h00, 0, 0, 1, 32'hDEADBEEF, 1, 8'h28, 0, 8'h04, NOP};
    tbl[11] = '{0, 8'h00, 0, 1, 0, 32'h0,        0, 8'h28, 0, 8'h04, NOP};
    tbl[12] = '{0, 8'h00, 0, 0, 1, 32'h11111111, 1, 8'h2C, 1, 8'h28, 32'h11111111};
    tbl[13] = '{1, 8'hFC, 0, 0, 0, 32'h0,        1, 8'hFC, 0, 8'h28, NOP};
    tbl[14] = '{0, 8'h00, 0, 1, 0, 32'h0,        0, 8'hFC, 0, 8'h28, NOP};
    tbl[15] = '{0, 8'h00, 0, 0, 1, 32'h22222222, 1, 8'h00, 1, 8'hFC, 32'h22222222};
    tbl[16] = '{1, 8'h40, 1, 1, 0, 32'h0,        0, 8'h40, 0, 8'hFC, NOP};
    tbl[17] = '{0, 8'h00, 0, 0, 1, 32'h33333333, 1, 8'h40, 0, 8'hFC, NOP};
    tbl[18] = '{0, 8'h00, 0, 1, 0, 32'h0,        0, 8'h40, 0, 8'hFC, NOP};
    tbl[19] = '{0, 8'h00, 1, 0, 1, 32'h44444444, 0, 8'h40, 0, 8'hFC, NOP};
    tbl[20] = '{1, 8'h80, 1, 0, 0, 32'h0,        1, 8'h80, 0, 8'hFC, NOP};
    tbl[21] = '{0, 8'h00, 0, 1, 0, 32'h0,        0, 8'h80, 0, 8'hFC, NOP};
    tbl[22] = '{1, 8'h90, 0, 0, 1, 32'h55555555, 1, 8'h90, 0, 8'hFC, NOP};
    tbl[23] = '{0, 8'h00, 0, 1, 0, 32'h0,        0, 8'h90, 0, 8'hFC, NOP};

    #12;
    chk_all("reset", 0, 8'h00, 0, 8'h00, NOP);
    rst_n = 1;
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].rd, tbl[i].ea, tbl[i].st, tbl[i].rdy, tbl[i].rv, tbl[i].rdat);
      @(posedge clk); #1;
      chk_all($sformatf("row%0d", i), tbl[i].req, tbl[i].addr, tbl[i].v, tbl[i].pc, tbl[i].ins);
    end

    drive(0, 8'h00, 0, 0, 0, 32'h0);
    #2 rst_n = 0;
    #1 chk_all("async_reset", 0, 8'h00, 0, 8'h00, NOP);
    drive(0, 8'h00, 0, 0, 1, 32'h66666666);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1 chk_all("stale_rvalid1", 1, 8'h00, 0, 8'h00, NOP);
    @(posedge clk); #1 chk_all("stale_rvalid2", 1, 8'h00, 0, 8'h00, NOP);
    drive(0, 8'h00, 0, 1, 0, 32'h0);
    @(posedge clk); #1 chk_all("post_reset_accept", 0, 8'h00, 0, 8'h00, NOP);
    drive(0, 8'h00, 0, 0, 1, 32'h77777777);
    @(posedge clk); #1 chk_all("post_reset_fetch", 1, 8'h04, 1, 8'h00, 32'h77777777);

    drive(0, 8'h00, 0, 0, 0, 32'h0);
    rst_n = 0;
    model_reset();
    @(posedge clk); #1 rst_n = 1;
    for (int c = 0; c < 3000; c++) begin
      logic rd, st, rdy, rv;
      logic [7:0] ea;
      logic [31:0] rdat;
      rd = ($urandom % 10) == 0;
      ea = ($urandom % 4) == 0 ? 8'hFC : 8'($urandom);
      st = ($urandom % 3) == 0;
      rdy = 1'($urandom % 2);
      rv = m_busy ? 1'($urandom % 2) : (($urandom % 8) == 0);
      rdat = m_busy ? word(m_req_addr) : $urandom;
      drive(rd, ea, st, rdy, rv, rdat);
      @(posedge clk);
      model_step(rd, ea, st, rdy, rv, rdat);
      #1 chk_all($sformatf("rand%0d", c), m_started && !m_busy && m_held.size() == 0,
                 m_pc, m_valid, m_ifpc, m_instr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
